// File: rtl/vx_perf_memsys_collector.sv
// Memory-system performance counter collector: accumulates cache/smem event
// increments and derives external memory read/write counts and read latency.
module vx_perf_memsys_collector #(
  parameter int PERF_CTR_BITS = 44,
  parameter int EVT_W         = 4,
  parameter int PEND_W        = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     perf_en,
  input  logic [EVT_W-1:0]         icache_reads_inc,
  input  logic [EVT_W-1:0]         icache_read_misses_inc,
  input  logic [EVT_W-1:0]         dcache_reads_inc,
  input  logic [EVT_W-1:0]         dcache_writes_inc,
  input  logic [EVT_W-1:0]         dcache_read_misses_inc,
  input  logic [EVT_W-1:0]         dcache_write_misses_inc,
  input  logic [EVT_W-1:0]         dcache_bank_stalls_inc,
  input  logic [EVT_W-1:0]         dcache_mshr_stalls_inc,
  input  logic [EVT_W-1:0]         smem_reads_inc,
  input  logic [EVT_W-1:0]         smem_writes_inc,
  input  logic [EVT_W-1:0]         smem_bank_stalls_inc,
  input  logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  input  logic                     mem_req_rw,
  input  logic                     mem_rsp_valid,
  input  logic                     mem_rsp_ready,
  output logic [PERF_CTR_BITS-1:0] icache_reads,
  output logic [PERF_CTR_BITS-1:0] icache_read_misses,
  output logic [PERF_CTR_BITS-1:0] dcache_reads,
  output logic [PERF_CTR_BITS-1:0] dcache_writes,
  output logic [PERF_CTR_BITS-1:0] dcache_read_misses,
  output logic [PERF_CTR_BITS-1:0] dcache_write_misses,
  output logic [PERF_CTR_BITS-1:0] dcache_bank_stalls,
  output logic [PERF_CTR_BITS-1:0] dcache_mshr_stalls,
  output logic [PERF_CTR_BITS-1:0] smem_reads,
  output logic [PERF_CTR_BITS-1:0] smem_writes,
  output logic [PERF_CTR_BITS-1:0] smem_bank_stalls,
  output logic [PERF_CTR_BITS-1:0] mem_reads,
  output logic [PERF_CTR_BITS-1:0] mem_writes,
  output logic [PERF_CTR_BITS-1:0] mem_latency,
  output logic                     pend_err
);

  localparam int NUM_EVT = 11;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [EVT_W-1:0]         evt_inc [NUM_EVT];
  logic [PERF_CTR_BITS-1:0] evt_ctr [NUM_EVT];
  logic [PEND_W-1:0]        pend;
  logic                     req_fire, rd_fire, wr_fire, rsp_fire;

  assign evt_inc[0]  = icache_reads_inc;
  assign evt_inc[1]  = icache_read_misses_inc;
  assign evt_inc[2]  = dcache_reads_inc;
  assign evt_inc[3]  = dcache_writes_inc;
  assign evt_inc[4]  = dcache_read_misses_inc;
  assign evt_inc[5]  = dcache_write_misses_inc;
  assign evt_inc[6]  = dcache_bank_stalls_inc;
  assign evt_inc[7]  = dcache_mshr_stalls_inc;
  assign evt_inc[8]  = smem_reads_inc;
  assign evt_inc[9]  = smem_writes_inc;
  assign evt_inc[10] = smem_bank_stalls_inc;

  assign req_fire = mem_req_valid & mem_req_ready;
  assign rd_fire  = req_fire & ~mem_req_rw;
  assign wr_fire  = req_fire & mem_req_rw;
  assign rsp_fire = mem_rsp_valid & mem_rsp_ready;

  for (genvar i = 0; i < NUM_EVT; i++) begin : g_evt
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        evt_ctr[i] <= '0;
      end else if (perf_en) begin
        evt_ctr[i] <= evt_ctr[i] + PERF_CTR_BITS'(evt_inc[i]);
      end
    end
  end

  // Latency integrates the pre-update outstanding count, so a read accepted
  // at edge N and answered at edge M contributes exactly M-N cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_reads   <= '0;
      mem_writes  <= '0;
      mem_latency <= '0;
    end else if (perf_en) begin
      mem_reads   <= mem_reads + PERF_CTR_BITS'(rd_fire);
      mem_writes  <= mem_writes + PERF_CTR_BITS'(wr_fire);
      mem_latency <= mem_latency + PERF_CTR_BITS'(pend);
    end
  end

  // The tracker runs regardless of perf_en so gating never loses sync.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend     <= '0;
      pend_err <= 1'b0;
    end else if (rd_fire && !rsp_fire) begin
      if (pend == PEND_MAX) begin
        pend_err <= 1'b1;
      end else begin
        pend <= pend + 1'b1;
      end
    end else if (rsp_fire && !rd_fire) begin
      if (pend == '0) begin
        pend_err <= 1'b1;
      end else begin
        pend <= pend - 1'b1;
      end
    end
  end

  assign icache_reads        = evt_ctr[0];
  assign icache_read_misses  = evt_ctr[1];
  assign dcache_reads        = evt_ctr[2];
  assign dcache_writes       = evt_ctr[3];
  assign dcache_read_misses  = evt_ctr[4];
  assign dcache_write_misses = evt_ctr[5];
  assign dcache_bank_stalls  = evt_ctr[6];
  assign dcache_mshr_stalls  = evt_ctr[7];
  assign smem_reads          = evt_ctr[8];
  assign smem_writes         = evt_ctr[9];
  assign smem_bank_stalls    = evt_ctr[10];

endmodule

// File: tb/tb_vx_perf_memsys_collector.sv
// Bench for vx_perf_memsys_collector: directed scenarios plus random traffic
// compared against a queue-based model of outstanding reads.
module tb_vx_perf_memsys_collector;

  localparam longint unsigned MASK_BIG = (64'd1 << 44) - 1;
  localparam longint unsigned MASK_SML = 64'hff;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       perf_en;
  logic [3:0] inc [11];
  logic       mem_req_valid, mem_req_ready, mem_req_rw;
  logic       mem_rsp_valid, mem_rsp_ready;
  logic [43:0] big [14];
  logic [7:0]  sml [14];
  logic        pend_err_big, pend_err_sml;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  longint unsigned sum [14];
  int              outstanding [$];
  logic            err_m;

  always #5 clk = ~clk;

  vx_perf_memsys_collector dut (
    .clk(clk), .reset_n(reset_n), .perf_en(perf_en),
    .icache_reads_inc(inc[0]), .icache_read_misses_inc(inc[1]),
    .dcache_reads_inc(inc[2]), .dcache_writes_inc(inc[3]),
    .dcache_read_misses_inc(inc[4]), .dcache_write_misses_inc(inc[5]),
    .dcache_bank_stalls_inc(inc[6]), .dcache_mshr_stalls_inc(inc[7]),
    .smem_reads_inc(inc[8]), .smem_writes_inc(inc[9]), .smem_bank_stalls_inc(inc[10]),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .icache_reads(big[0]), .icache_read_misses(big[1]),
    .dcache_reads(big[2]), .dcache_writes(big[3]),
    .dcache_read_misses(big[4]), .dcache_write_misses(big[5]),
    .dcache_bank_stalls(big[6]), .dcache_mshr_stalls(big[7]),
    .smem_reads(big[8]), .smem_writes(big[9]), .smem_bank_stalls(big[10]),
    .mem_reads(big[11]), .mem_writes(big[12]), .mem_latency(big[13]),
    .pend_err(pend_err_big)
  );

  vx_perf_memsys_collector #(.PERF_CTR_BITS(8)) dut_small (
    .clk(clk), .reset_n(reset_n), .perf_en(perf_en),
    .icache_reads_inc(inc[0]), .icache_read_misses_inc(inc[1]),
    .dcache_reads_inc(inc[2]), .dcache_writes_inc(inc[3]),
    .dcache_read_misses_inc(inc[4]), .dcache_write_misses_inc(inc[5]),
    .dcache_bank_stalls_inc(inc[6]), .dcache_mshr_stalls_inc(inc[7]),
    .smem_reads_inc(inc[8]), .smem_writes_inc(inc[9]), .smem_bank_stalls_inc(inc[10]),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .icache_reads(sml[0]), .icache_read_misses(sml[1]),
    .dcache_reads(sml[2]), .dcache_writes(sml[3]),
    .dcache_read_misses(sml[4]), .dcache_write_misses(sml[5]),
    .dcache_bank_stalls(sml[6]), .dcache_mshr_stalls(sml[7]),
    .smem_reads(sml[8]), .smem_writes(sml[9]), .smem_bank_stalls(sml[10]),
    .mem_reads(sml[11]), .mem_writes(sml[12]), .mem_latency(sml[13]),
    .pend_err(pend_err_sml)
  );

  task automatic checkVal(input string tag, input longint unsigned obs, input longint unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput(input string ctx);
    for (int i = 0; i < 14; i++) begin
      checkVal($sformatf("%s_ctr%0d", ctx, i), longint'(big[i]), sum[i] & MASK_BIG);
      checkVal($sformatf("%s_small_ctr%0d", ctx, i), longint'(sml[i]), sum[i] & MASK_SML);
    end
    checkVal({ctx, "_pend_err"}, longint'(pend_err_big), longint'(err_m));
    checkVal({ctx, "_small_pend_err"}, longint'(pend_err_sml), longint'(err_m));
  endtask

  task automatic setIdle();
    perf_en = 1'b1;
    for (int i = 0; i < 11; i++) inc[i] = 4'd0;
    mem_req_valid = 1'b0; mem_req_ready = 1'b0; mem_req_rw = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_ready = 1'b0;
  endtask

  // One clock edge with the currently driven inputs; the model follows the
  // spec rules: counters are sums, latency adds the number of reads in flight.
  task automatic applyStimulus();
    logic rd, wr, rsp;
    rd  = mem_req_valid & mem_req_ready & ~mem_req_rw;
    wr  = mem_req_valid & mem_req_ready & mem_req_rw;
    rsp = mem_rsp_valid & mem_rsp_ready;
    @(posedge clk);
    if (perf_en) begin
      for (int i = 0; i < 11; i++) sum[i] += longint'(inc[i]);
      sum[11] += longint'(rd);
      sum[12] += longint'(wr);
      sum[13] += longint'(outstanding.size());
    end
    if (rd && !rsp) begin
      if (outstanding.size() == 255) err_m = 1'b1;
      else outstanding.push_back(cyc);
    end else if (rsp && !rd) begin
      if (outstanding.size() == 0) err_m = 1'b1;
      else void'(outstanding.pop_front());
    end
    cyc++;
    #1;
  endtask

  task automatic doReset(input string ctx);
    setIdle();
    #1 reset_n = 1'b0;
    for (int i = 0; i < 14; i++) sum[i] = 0;
    outstanding.delete();
    err_m = 1'b0;
    #1 checkOutput(ctx);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic readReq();
    setIdle();
    mem_req_valid = 1'b1; mem_req_ready = 1'b1; mem_req_rw = 1'b0;
  endtask

  task automatic idleSteps(input int n);
    setIdle();
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    longint unsigned lat0;
    for (int i = 0; i < 14; i++) sum[i] = 0;
    err_m = 1'b0;
    setIdle();
    reset_n = 1'b0;
    #2 checkOutput("por");
    @(negedge clk);
    reset_n = 1'b1;

    // Cache increments
    setIdle();
    inc[2] = 4'd3;
    for (int i = 0; i < 5; i++) applyStimulus();
    setIdle();
    inc[10] = 4'd15;
    for (int i = 0; i < 2; i++) applyStimulus();
    checkOutput("cache");
    checkVal("dcache_reads_15", longint'(big[2]), 15);
    checkVal("smem_bank_stalls_30", longint'(big[10]), 30);

    // Single read, response 10 cycles later
    doReset("rst_lat1");
    readReq(); applyStimulus();
    idleSteps(9);
    setIdle(); mem_rsp_valid = 1'b1; mem_rsp_ready = 1'b1; applyStimulus();
    checkOutput("lat1");
    checkVal("lat1_reads", longint'(big[11]), 1);
    checkVal("lat1_latency", longint'(big[13]), 10);

    // Overlapping reads at cycles 0 and 2, responses at 6 and 10
    doReset("rst_lat2");
    readReq(); applyStimulus();
    idleSteps(1);
    readReq(); applyStimulus();
    idleSteps(3);
    setIdle(); mem_rsp_valid = 1'b1; mem_rsp_ready = 1'b1; applyStimulus();
    idleSteps(3);
    setIdle(); mem_rsp_valid = 1'b1; mem_rsp_ready = 1'b1; applyStimulus();
    checkOutput("lat2");
    checkVal("lat2_latency", longint'(big[13]), 14);

    // Simultaneous read and response with two in flight, then a write
    doReset("rst_simul");
    readReq(); applyStimulus();
    readReq(); applyStimulus();
    readReq(); mem_rsp_valid = 1'b1; mem_rsp_ready = 1'b1; applyStimulus();
    setIdle(); mem_req_valid = 1'b1; mem_req_ready = 1'b1; mem_req_rw = 1'b1; applyStimulus();
    lat0 = longint'(big[13]);
    idleSteps(1);
    checkOutput("simul");
    checkVal("simul_reads", longint'(big[11]), 3);
    checkVal("simul_writes", longint'(big[12]), 1);
    checkVal("simul_pend_delta", longint'(big[13]) - lat0, 2);

    // Underflow sets a sticky error
    doReset("rst_under");
    setIdle(); mem_rsp_valid = 1'b1; mem_rsp_ready = 1'b1; applyStimulus();
    checkVal("under_err", longint'(pend_err_big), 1);
    idleSteps(3);
    checkOutput("under_sticky");
    checkVal("under_err_sticky", longint'(pend_err_big), 1);

    // 256 reads without responses saturate the tracker at 255
    doReset("rst_sat");
    readReq();
    for (int i = 0; i < 256; i++) applyStimulus();
    checkVal("sat_err", longint'(pend_err_big), 1);
    lat0 = longint'(big[13]);
    idleSteps(1);
    checkOutput("sat");
    checkVal("sat_delta", longint'(big[13]) - lat0, 255);

    // Gating with one read outstanding
    doReset("rst_gate");
    readReq(); applyStimulus();
    lat0 = longint'(big[13]);
    setIdle(); perf_en = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus();
    checkVal("gate_frozen", longint'(big[13]), lat0);
    idleSteps(3);
    checkOutput("gate");
    checkVal("gate_resume", longint'(big[13]) - lat0, 3);

    // 8-bit counter wrap
    doReset("rst_wrap");
    setIdle(); inc[0] = 4'd1;
    for (int i = 0; i < 255; i++) applyStimulus();
    checkVal("wrap_255", longint'(sml[0]), 255);
    applyStimulus();
    checkVal("wrap_0", longint'(sml[0]), 0);
    checkVal("wrap_big_256", longint'(big[0]), 256);

    // Random traffic
    doReset("rst_rand");
    for (int n = 0; n < 400; n++) begin
      perf_en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < 11; i++) inc[i] = 4'($urandom_range(0, 15));
      mem_req_valid = 1'($urandom);
      mem_req_ready = 1'($urandom);
      mem_req_rw    = 1'($urandom);
      mem_rsp_valid = (outstanding.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rsp_ready = 1'($urandom);
      applyStimulus();
      checkOutput("rand");
    end

    // Asynchronous reset between clock edges with counters nonzero
    checkVal("pre_reset_nonzero", longint'(big[2] != 0), 1);
    doReset("async_rst");
    idleSteps(1);
    checkOutput("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_perf_memsys_collector.md
Name: vx_perf_memsys_collector

Overview:
- Producer (master side) of the memory-system performance-counter bundle consumed by the CSR/perf readout logic.
- Accumulates per-cycle event increments from icache, dcache and shared memory into 64-bit-class counters.
- Observes the core's external memory request/response handshake to derive read count, write count and cumulative read latency.
- Sits between the cache/memory subsystem and the CSR unit, one instance per core.

Parameters:
- PERF_CTR_BITS, 44, width of every output counter.
- EVT_W, 4, width of each per-cycle event-increment input (max 15 events/cycle).
- PEND_W, 8, width of the outstanding-read tracker (max 255 in flight).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- perf_en  in  1  1 = counters accumulate; 0 = counters hold
- icache_reads_inc, icache_read_misses_inc  in  EVT_W  per-cycle icache event counts
- dcache_reads_inc, dcache_writes_inc, dcache_read_misses_inc, dcache_write_misses_inc, dcache_bank_stalls_inc, dcache_mshr_stalls_inc  in  EVT_W  per-cycle dcache event counts
- smem_reads_inc, smem_writes_inc, smem_bank_stalls_inc  in  EVT_W  per-cycle shared-memory event counts
- mem_req_valid, mem_req_ready  in  1  memory request handshake
- mem_req_rw  in  1  1 = write, 0 = read
- mem_rsp_valid, mem_rsp_ready  in  1  memory read-response handshake
- icache_reads ... mem_latency  out  PERF_CTR_BITS  the 14 counters of the memsys perf bundle, driven as its master
- pend_err  out  1  sticky tracker overflow/underflow flag

Behaviour:
- Reset:
  - Asynchronous assertion of reset_n=0 clears all 14 counters, the pending tracker and pend_err to 0 immediately.
  - Deassertion is used synchronously to clk.
- Event fire definitions:
  - req_fire = mem_req_valid & mem_req_ready.
  - rd_fire = req_fire & ~mem_req_rw.
  - wr_fire = req_fire & mem_req_rw.
  - rsp_fire = mem_rsp_valid & mem_rsp_ready.
- Cache/smem counters:
  - When perf_en=1, each counter adds its zero-extended *_inc input each cycle.
  - Latency is 1 cycle: increments applied at edge N are visible at the output after edge N.
- mem_reads and mem_writes:
  - When perf_en=1, mem_reads += rd_fire and mem_writes += wr_fire.
- Pending tracker (pend):
  - Always updates, independent of perf_en, so that disabling counting never desynchronises it.
  - rd_fire only: +1. rsp_fire only: -1. Both in the same cycle: unchanged. Neither: unchanged.
  - rsp_fire with pend=0 and no rd_fire: pend stays 0 and pend_err is set.
  - rd_fire with pend = 2^PEND_W-1 and no rsp_fire: pend saturates and pend_err is set.
  - pend_err clears only on reset.
- mem_latency:
  - When perf_en=1, mem_latency += pend each cycle, using the registered pend before this edge's update.
  - The total therefore equals the sum over completed and in-flight reads of the cycles spent outstanding.
- Arithmetic:
  - All counters wrap modulo 2^PERF_CTR_BITS with no saturation.
  - Additions are unsigned; inputs are zero-extended.
- perf_en:
  - perf_en=0 freezes all 14 outputs; pend and pend_err still update.
  - Re-enabling resumes accumulation with no catch-up.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset: drive reset_n=0 mid-run with counters nonzero -> all outputs 0 asynchronously, before the next clk edge; pend_err=0.
- Cache increments: perf_en=1, dcache_reads_inc=3 for 5 cycles and smem_bank_stalls_inc=15 for 2 cycles -> dcache_reads=15, smem_bank_stalls=30; all other cache counters stay 0.
- Read latency:
  - Single read accepted at cycle 0, response at cycle 10 -> mem_reads=1, mem_latency=10.
  - Second overlapping read issued at cycle 2, response at cycle 6 -> mem_latency=14.
- Simultaneous events: rd_fire and rsp_fire in the same cycle with pend=2 -> pend stays 2; mem_reads+1; a write (mem_req_rw=1) leaves pend unchanged and gives mem_writes+1.
- Error and gating:
  - rsp_fire with pend=0 -> pend_err=1 and remains 1.
  - 256 reads with no responses at PEND_W=8 -> pend saturates at 255 and pend_err=1.
  - perf_en=0 for 4 cycles with one read outstanding -> mem_latency unchanged; after re-enable it increments by 1 per cycle.
- Wrap: PERF_CTR_BITS=8, preload by 255 icache_reads increments, then +1 -> icache_reads=0.
